// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-controller bus bundle: instruction-memory req/ack, decode valid/ready, jump redirect.
// Signal names match the original inst_fetch_ctrl ports; master is the controller side.
interface inst_fetch_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  o_imem_req;
    logic [DATA_WIDTH-1:0] o_imem_addr;
    logic                  i_imem_ack;
    logic [DATA_WIDTH-1:0] i_imem_data;
    logic [DATA_WIDTH-1:0] o_inst;
    logic                  o_inst_valid;
    logic                  i_inst_ready;
    logic [DATA_WIDTH-1:0] o_npc;
    logic                  i_jump_valid;
    logic [DATA_WIDTH-1:0] i_jump_addr;
    logic [15:0]           o_jump_cnt;

    modport master (
        output o_imem_req, o_imem_addr, o_inst, o_inst_valid, o_npc, o_jump_cnt,
        input  i_imem_ack, i_imem_data, i_inst_ready, i_jump_valid, i_jump_addr
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_inst, o_inst_valid, o_npc, o_jump_cnt,
        output i_imem_ack, i_imem_data, i_inst_ready, i_jump_valid, i_jump_addr
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// PC and instruction-fetch controller: IDLE -> FETCH -> HOLD with jump redirect and squash.
// Optional taken-redirect counter enabled by defining IFC_JUMP_CNT_EN.
module inst_fetch_ctrl #(
    parameter int                    DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0
) (
    input logic                clk,
    input logic                rst_n,
    inst_fetch_ctrl_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  squash_q, squash_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] npc_q, npc_d;
    logic [DATA_WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + DATA_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        req_d    = req_q;
        addr_d   = addr_q;
        inst_d   = inst_q;
        valid_d  = valid_q;
        npc_d    = npc_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
                if (bus.i_jump_valid) begin
                    pc_d   = bus.i_jump_addr;
                    addr_d = bus.i_jump_addr;
                end else begin
                    addr_d = pc_q;
                end
            end

            FETCH: begin
                if (bus.i_jump_valid) begin
                    pc_d    = bus.i_jump_addr;
                    valid_d = 1'b0;
                    // Without an ack the request must stay stable, so remember to drop its data.
                    if (bus.i_imem_ack) begin
                        squash_d = 1'b0;
                        addr_d   = bus.i_jump_addr;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (bus.i_imem_ack) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        addr_d   = pc_q;
                    end else begin
                        inst_d  = bus.i_imem_data;
                        valid_d = 1'b1;
                        npc_d   = pc_inc;
                        pc_d    = pc_inc;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                if (bus.i_jump_valid) begin
                    pc_d    = bus.i_jump_addr;
                    addr_d  = bus.i_jump_addr;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (bus.i_inst_ready) begin
                    addr_d  = pc_q;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_ADDR;
            squash_q <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= RESET_ADDR;
            inst_q   <= '0;
            valid_q  <= 1'b0;
            npc_q    <= RESET_ADDR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            inst_q   <= inst_d;
            valid_q  <= valid_d;
            npc_q    <= npc_d;
        end
    end

    assign bus.o_imem_req   = req_q;
    assign bus.o_imem_addr  = addr_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_inst_valid = valid_q;
    assign bus.o_npc        = npc_q;

`ifdef IFC_JUMP_CNT_EN
    logic [15:0] jump_cnt_q, jump_cnt_d;

    always_comb begin
        jump_cnt_d = jump_cnt_q;
        if (bus.i_jump_valid && (jump_cnt_q != 16'hFFFF)) begin
            jump_cnt_d = jump_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jump_cnt_q <= '0;
        end else begin
            jump_cnt_q <= jump_cnt_d;
        end
    end

    assign bus.o_jump_cnt = jump_cnt_q;
`else
    assign bus.o_jump_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: random memory/decode/jump stimulus against a
// transaction-level model of which fetched words must reach decode and in what order.
module tb_inst_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_ctrl_if #(.DATA_WIDTH(16)) bus ();

    inst_fetch_ctrl #(
        .DATA_WIDTH(16),
        .RESET_ADDR(16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] inst;
        logic [15:0] npc;
    } exp_t;

    exp_t        sb[$];
    int          acc_cyc[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    // Reference model state
    bit          hold = 1'b0;
    bit          req_open = 1'b0;
    bit          dirty = 1'b0;
    logic [15:0] exp_addr = 16'h0000;
    logic [15:0] req_addr = 16'h0000;
    int          jcnt = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] r;
        r = a * 16'h0097;
        return r ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_jcnt();
`ifdef IFC_JUMP_CNT_EN
        return (jcnt > 16'hFFFF) ? 16'hFFFF : 16'(jcnt);
`else
        return 16'h0000;
`endif
    endfunction

    // Monitor: a handshake completes when the pre-edge output was valid, ready was high, no jump.
    initial begin
        bit          prev_valid;
        logic [15:0] prev_inst, prev_npc;
        exp_t        e;
        prev_valid = 1'b0;
        prev_inst  = '0;
        prev_npc   = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                if (prev_valid && bus.i_inst_ready && !bus.i_jump_valid) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL accept_unexpected: got inst %h npc %h expected none", prev_inst, prev_npc);
                    end else begin
                        e = sb.pop_front();
                        chk("accept_inst", prev_inst, e.inst);
                        chk("accept_npc", prev_npc, e.npc);
                    end
                    acc_cyc.push_back(cyc);
                end
                prev_valid = bus.o_inst_valid;
                prev_inst  = bus.o_inst;
                prev_npc   = bus.o_npc;
            end
        end
    end

    // One cycle: observe outputs at negedge, drive inputs, advance the model for the coming edge.
    task automatic step(input bit ack_en, input bit rdy, input bit jv, input logic [15:0] ja,
                        output bit saw_req, output bit saw_valid);
        bit          ackv;
        logic [15:0] nxt;
        @(negedge clk);
        saw_req   = bus.o_imem_req;
        saw_valid = bus.o_inst_valid;
        chk("req_level", {15'b0, bus.o_imem_req}, {15'b0, !hold});
        chk("valid_level", {15'b0, bus.o_inst_valid}, {15'b0, hold});
        if (hold && sb.size() > 0) begin
            chk("held_inst", bus.o_inst, sb[$].inst);
            chk("held_npc", bus.o_npc, sb[$].npc);
        end
        if (bus.o_imem_req) begin
            if (!req_open) begin
                chk("req_addr", bus.o_imem_addr, exp_addr);
                req_open = 1'b1;
                req_addr = bus.o_imem_addr;
                dirty    = 1'b0;
            end else begin
                chk("req_addr_stable", bus.o_imem_addr, req_addr);
            end
        end

        ackv = ack_en && bus.o_imem_req;
        bus.i_imem_ack   = ackv;
        bus.i_imem_data  = ackv ? mem_word(bus.o_imem_addr) : 16'($urandom);
        bus.i_inst_ready = rdy;
        bus.i_jump_valid = jv;
        bus.i_jump_addr  = jv ? ja : 16'($urandom);

        if (jv) begin
            jcnt++;
            exp_addr = ja;
            if (hold) begin
                void'(sb.pop_back());
                hold = 1'b0;
            end
            if (req_open) begin
                if (ackv) req_open = 1'b0;
                else      dirty = 1'b1;
            end
        end else begin
            if (hold && rdy) hold = 1'b0;
            if (ackv && req_open) begin
                req_open = 1'b0;
                if (!dirty) begin
                    nxt = req_addr + 16'd1;
                    sb.push_back('{inst: mem_word(req_addr), npc: nxt});
                    exp_addr = nxt;
                    hold = 1'b1;
                end
            end
        end
    endtask

    task automatic reset_model();
        sb.delete();
        hold     = 1'b0;
        req_open = 1'b0;
        dirty    = 1'b0;
        exp_addr = 16'h0000;
        jcnt     = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {15'b0, bus.o_imem_req}, 16'h0000);
        chk({tag, "_addr"}, bus.o_imem_addr, 16'h0000);
        chk({tag, "_inst"}, bus.o_inst, 16'h0000);
        chk({tag, "_valid"}, {15'b0, bus.o_inst_valid}, 16'h0000);
        chk({tag, "_npc"}, bus.o_npc, 16'h0000);
        chk({tag, "_jcnt"}, bus.o_jump_cnt, 16'h0000);
    endtask

    // Release at a negedge with a stray ack that IDLE must ignore.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_imem_ack   = 1'b1;
        bus.i_imem_data  = 16'hDEAD;
        bus.i_inst_ready = 1'b1;
        bus.i_jump_valid = 1'b0;
    endtask

    task automatic wait_for(input bit want_req, input bit ack_en, input bit rdy, input string name);
        bit r, v, hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            step(ack_en, rdy, 1'b0, 16'h0000, r, v);
            hit = want_req ? r : v;
        end
        if (!hit) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_%s: got timeout expected event within 40 cycles", name);
        end
    endtask

    initial begin
        bit r, v;
        int base;
        bus.i_imem_ack   = 1'b0;
        bus.i_imem_data  = '0;
        bus.i_inst_ready = 1'b0;
        bus.i_jump_valid = 1'b0;
        bus.i_jump_addr  = '0;
        reset_model();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_reset();

        // Back-to-back fetches with immediate ack and ready.
        base = acc_cyc.size();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);
        chk("stream_count_ge4", {15'b0, (acc_cyc.size() - base) >= 4}, 16'h0001);
        if (acc_cyc.size() - base >= 4) begin
            for (int i = 1; i < 4; i++)
                chk("stream_spacing", 16'(acc_cyc[base + i] - acc_cyc[base + i - 1]), 16'd2);
        end

        // Decode stall in HOLD.
        wait_for(1'b0, 1'b1, 1'b0, "stall_valid");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, r, v);
        step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);

        // Jump while holding with ready high.
        wait_for(1'b0, 1'b1, 1'b0, "hold_jump");
        step(1'b1, 1'b1, 1'b1, 16'h0040, r, v);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);

        // Jumps while a request waits for a delayed ack.
        wait_for(1'b1, 1'b0, 1'b1, "pending_req");
        step(1'b0, 1'b1, 1'b1, 16'h0100, r, v);
        step(1'b0, 1'b1, 1'b0, 16'h0000, r, v);
        step(1'b0, 1'b1, 1'b1, 16'h0200, r, v);
        step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);

        // Jump coincident with ack.
        wait_for(1'b1, 1'b0, 1'b1, "ack_jump");
        step(1'b1, 1'b1, 1'b1, 16'h0040, r, v);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);

        // PC wrap at all-ones.
        step(1'b1, 1'b1, 1'b1, 16'hFFFF, r, v);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] ja;
            case ($urandom_range(0, 3))
                0:       ja = 16'hFFFF;
                1:       ja = 16'hFFFE;
                2:       ja = 16'h0040;
                default: ja = 16'($urandom);
            endcase
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 99) < 8, ja, r, v);
        end
        @(negedge clk);
        chk("jump_cnt_random", bus.o_jump_cnt, exp_jcnt());

        // Asynchronous reset in the middle of a request.
        wait_for(1'b1, 1'b0, 1'b1, "reset_req");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreq_reset");
        reset_model();
        release_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);

        // Three jumps after reset.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 16'(16'h0300 + i), r, v);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0000, r, v);
        @(negedge clk);
        chk("jump_cnt_three", bus.o_jump_cnt, exp_jcnt());
        @(posedge clk);
        #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
